// File: rtl/iic_slave_regs.sv
// rtl/iic_slave_regs.sv - I2C target giving an external master byte access to a local register bank
module iic_slave_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter bit         ADDR_16BIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iic_clk,
    inout  wire         iic_sda,
    output logic [15:0] reg_addr,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        wr_done
);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
        WDATA, ACK_W, RDATA, MACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_q, sda_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic [15:0] reg_addr_q, reg_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_req_q, rd_req_d;
    logic        rd_load_q, rd_load_d;
    logic        busy_q, busy_d;
    logic        wr_done_q, wr_done_d;
    logic        written_q, written_d;
    logic        sda_oe_q, sda_oe_d;

    logic        scl_rise, scl_fall, start_c, stop_c, last_bit;
    logic [7:0]  rx_byte;

    // scl_q/sda_q: [0],[1] synchronizer, [2] history for edge detection
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start_c  = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_c   = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign rx_byte  = {rx_q[6:0], sda_q[1]};
    assign last_bit = (cnt_q == 3'd7);

    function automatic logic [15:0] next_ptr(input logic [15:0] p);
        if (ADDR_16BIT) begin
            return p + 16'd1;
        end
        return {8'h00, p[7:0] + 8'd1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q      <= 3'b111;
            sda_q      <= 3'b111;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            rw_q       <= 1'b0;
            reg_addr_q <= 16'h0000;
            wr_data_q  <= 8'h00;
            wr_en_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_load_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_done_q  <= 1'b0;
            written_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            scl_q      <= {scl_q[1:0], iic_clk};
            sda_q      <= {sda_q[1:0], iic_sda};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_req_q   <= rd_req_d;
            rd_load_q  <= rd_load_d;
            busy_q     <= busy_d;
            wr_done_q  <= wr_done_d;
            written_q  <= written_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_req_d   = 1'b0;
        rd_load_d  = rd_req_q;
        busy_d     = busy_q;
        wr_done_d  = 1'b0;
        written_d  = written_q;
        sda_oe_d   = sda_oe_q;

        // bank answers one clk after rd_req; capture the byte the clk after that
        if (rd_load_q) begin
            tx_d = rd_data;
        end

        if (stop_c) begin
            state_d   = IDLE;
            cnt_d     = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            wr_done_d = written_q;
            written_d = 1'b0;
        end else if (start_c) begin
            state_d  = DEV;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else begin
            if (scl_fall) begin
                sda_oe_d = (state_q == ACK_DEV) || (state_q == ACK_AH) ||
                           (state_q == ACK_AL)  || (state_q == ACK_W)  ||
                           ((state_q == RDATA) && !tx_q[7]);
            end
            if (scl_rise) begin
                case (state_q)
                    DEV, ADDR_H, ADDR_L, WDATA: begin
                        rx_d  = rx_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (last_bit) begin
                            case (state_q)
                                DEV: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_d = ACK_DEV;
                                        rw_d    = rx_byte[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = WAIT_STOP;
                                    end
                                end
                                ADDR_H: begin
                                    reg_addr_d[15:8] = rx_byte;
                                    state_d          = ACK_AH;
                                end
                                ADDR_L: begin
                                    reg_addr_d[7:0] = rx_byte;
                                    state_d         = ACK_AL;
                                end
                                default: begin
                                    wr_data_d = rx_byte;
                                    wr_en_d   = 1'b1;
                                    written_d = 1'b1;
                                    state_d   = ACK_W;
                                end
                            endcase
                        end
                    end
                    ACK_DEV: begin
                        if (rw_q) begin
                            rd_req_d = 1'b1;
                            state_d  = RDATA;
                        end else begin
                            state_d = ADDR_16BIT ? ADDR_H : ADDR_L;
                        end
                    end
                    ACK_AH: state_d = ADDR_L;
                    ACK_AL: state_d = WDATA;
                    ACK_W: begin
                        reg_addr_d = next_ptr(reg_addr_q);
                        state_d    = WDATA;
                    end
                    RDATA: begin
                        tx_d  = {tx_q[6:0], 1'b0};
                        cnt_d = cnt_q + 3'd1;
                        if (last_bit) begin
                            state_d = MACK;
                        end
                    end
                    MACK: begin
                        if (!sda_q[1]) begin
                            reg_addr_d = next_ptr(reg_addr_q);
                            rd_req_d   = 1'b1;
                            state_d    = RDATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign iic_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr = reg_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign rd_req   = rd_req_q;
    assign busy     = busy_q;
    assign wr_done  = wr_done_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// tb/tb_iic_slave_regs.sv - two targets (16-bit @0x50, 8-bit @0x2C) on one bus, scoreboard against a byte-level model
module tb_iic_slave_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_low = 1'b0;
    wire  iic_sda;
    pullup (iic_sda);
    assign iic_sda = sda_low ? 1'b0 : 1'bz;

    logic [15:0] reg_addr0, reg_addr1;
    logic        wr_en0, wr_en1, rd_req0, rd_req1, busy0, busy1, wr_done0, wr_done1;
    logic [7:0]  wr_data0, wr_data1;
    logic [7:0]  rd_data0 = 8'h00;
    logic [7:0]  rd_data1 = 8'h00;

    iic_slave_regs #(.DEV_ADDR(7'h50), .ADDR_16BIT(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .iic_clk(scl_m), .iic_sda(iic_sda),
        .reg_addr(reg_addr0), .wr_en(wr_en0), .wr_data(wr_data0), .rd_req(rd_req0),
        .rd_data(rd_data0), .busy(busy0), .wr_done(wr_done0)
    );

    iic_slave_regs #(.DEV_ADDR(7'h2C), .ADDR_16BIT(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .iic_clk(scl_m), .iic_sda(iic_sda),
        .reg_addr(reg_addr1), .wr_en(wr_en1), .wr_data(wr_data1), .rd_req(rd_req1),
        .rd_data(rd_data1), .busy(busy1), .wr_done(wr_done1)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h0012) return 8'h5A;
        if (a == 16'h0013) return 8'hC3;
        return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h3C;
    endfunction

    // Register banks seen by the DUTs: one-clk read latency
    logic [7:0] bank0 [65536];
    logic [7:0] bank1 [65536];
    logic       bank_init = 1'b0;
    always @(posedge clk) begin
        if (!bank_init) begin
            for (int i = 0; i < 65536; i++) begin
                bank0[i] <= init_val(16'(i));
                bank1[i] <= init_val(16'(i) ^ 16'h00A5);
            end
            bank_init <= 1'b1;
        end else begin
            if (rd_req0) rd_data0 <= bank0[reg_addr0];
            if (wr_en0)  bank0[reg_addr0] <= wr_data0;
            if (rd_req1) rd_data1 <= bank1[reg_addr1];
            if (wr_en1)  bank1[reg_addr1] <= wr_data1;
        end
    end

    typedef struct {
        int          kind;
        int          inst;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t         sbq[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          busy_cnt[2];
    int          busy_snap[2];
    logic [7:0]  wq[$];
    logic [7:0]  mem_m [2][65536];
    logic [15:0] ptr_m [2];

    function automatic logic [15:0] nxt(input int inst, input logic [15:0] p);
        return (inst == 0) ? p + 16'd1 : {8'h00, p[7:0] + 8'd1};
    endfunction

    function automatic logic [15:0] clip(input int inst, input logic [15:0] a);
        return (inst == 0) ? a : {8'h00, a[7:0]};
    endfunction

    function automatic logic [7:0] dev(input int inst, input logic rw);
        return {(inst == 0) ? 7'h50 : 7'h2C, rw};
    endfunction

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    task automatic push_ev(input int k, input int inst, input logic [15:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.inst = inst; e.addr = a; e.data = d;
        sbq.push_back(e);
    endtask

    // kind: 1 = wr_en (addr,data), 2 = rd_req (addr), 3 = wr_done
    task automatic sb_check(input int k, input int inst, input logic [15:0] a, input logic [7:0] d);
        ev_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: got kind %0d inst %0d addr %h data %h, required no event", k, inst, a, d);
        end else begin
            e = sbq.pop_front();
            chk("sb_event", {8'(k), 8'(inst), a, d}, {8'(e.kind), 8'(e.inst), e.addr, e.data});
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_low = ~b;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        @(negedge clk);
        r = iic_sda;
        wait_clk(5);
        scl_m = 1'b0;
        wait_clk(5);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(~ack, r);
    endtask

    task automatic do_start();
        sda_low = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        sda_low = 1'b1;
        wait_clk(5);
        scl_m = 1'b0;
        wait_clk(5);
    endtask

    task automatic do_stop();
        sda_low = 1'b1;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(5);
        sda_low = 1'b0;
        wait_clk(10);
    endtask

    task automatic begin_txn();
        busy_snap[0] = busy_cnt[0];
        busy_snap[1] = busy_cnt[1];
    endtask

    task automatic post_check(input int who);
        chk("sb_drained", 40'(sbq.size()), 40'(0));
        sbq.delete();
        chk("reg_addr0", 40'(reg_addr0), 40'(ptr_m[0]));
        chk("reg_addr1", 40'(reg_addr1), 40'(ptr_m[1]));
        for (int i = 0; i < 2; i++)
            chk("busy_seen", 40'(busy_cnt[i] != busy_snap[i]), 40'(who == i));
        chk("busy_idle", 40'({busy1, busy0}), 40'(0));
    endtask

    task automatic send_addr(input int inst, input logic [15:0] a);
        logic ack;
        if (inst == 0) begin
            send_byte(a[15:8], ack);
            chk("ack_addr_h", 40'(ack), 40'(1));
        end
        send_byte(a[7:0], ack);
        chk("ack_addr_l", 40'(ack), 40'(1));
    endtask

    task automatic wr_txn(input int inst, input logic [15:0] a, input bit abort);
        logic ack, r;
        logic [15:0] p;
        begin_txn();
        p = clip(inst, a);
        foreach (wq[k]) begin
            push_ev(1, inst, p, wq[k]);
            mem_m[inst][p] = wq[k];
            p = nxt(inst, p);
        end
        if (wq.size() > 0) push_ev(3, inst, 16'h0000, 8'h00);
        ptr_m[inst] = p;
        do_start();
        send_byte(dev(inst, 1'b0), ack);
        chk("ack_dev_w", 40'(ack), 40'(1));
        send_addr(inst, a);
        foreach (wq[k]) begin
            send_byte(wq[k], ack);
            chk("ack_wdata", 40'(ack), 40'(1));
        end
        if (abort) for (int i = 0; i < 4; i++) bit_x(1'($urandom), r);
        do_stop();
        post_check(inst);
    endtask

    task automatic rd_txn(input int inst, input bit set, input logic [15:0] a, input int n);
        logic ack;
        logic [7:0] d;
        logic [7:0] expq[$];
        logic [15:0] p;
        begin_txn();
        if (set) ptr_m[inst] = clip(inst, a);
        p = ptr_m[inst];
        for (int k = 0; k < n; k++) begin
            push_ev(2, inst, p, 8'h00);
            expq.push_back(mem_m[inst][p]);
            if (k < n - 1) p = nxt(inst, p);
        end
        ptr_m[inst] = p;
        do_start();
        if (set) begin
            send_byte(dev(inst, 1'b0), ack);
            chk("ack_dev_w", 40'(ack), 40'(1));
            send_addr(inst, a);
            do_start();
        end
        send_byte(dev(inst, 1'b1), ack);
        chk("ack_dev_r", 40'(ack), 40'(1));
        for (int k = 0; k < n; k++) begin
            recv_byte(k < n - 1, d);
            chk("rdata", 40'(d), 40'(expq[k]));
        end
        do_stop();
        post_check(inst);
    endtask

    task automatic wrong_txn();
        logic ack;
        begin_txn();
        do_start();
        send_byte(8'hA2, ack);
        chk("nack_dev", 40'(ack), 40'(0));
        repeat (2) begin
            send_byte(8'($urandom), ack);
            chk("nack_data", 40'(ack), 40'(0));
        end
        do_stop();
        post_check(-1);
    endtask

    task automatic reset_mid_ack();
        logic r;
        logic [7:0] b;
        begin_txn();
        do_start();
        b = dev(0, 1'b0);
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        sda_low = 1'b0;
        wait_clk(1);
        @(negedge clk);
        chk("ack_drive_low", 40'(iic_sda), 40'(0));
        chk("busy_addressed", 40'(busy0), 40'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_sda_released", 40'(iic_sda), 40'(1));
        chk("rst_outputs0", 40'({reg_addr0, wr_data0, wr_en0, rd_req0, busy0, wr_done0}), 40'(0));
        chk("rst_outputs1", 40'({reg_addr1, wr_data1, wr_en1, rd_req1, busy1, wr_done1}), 40'(0));
        ptr_m[0] = 16'h0000;
        ptr_m[1] = 16'h0000;
        wait_clk(3);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(2);
        do_stop();
        post_check(0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int inst, kind, n;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            mem_m[0][i] = init_val(16'(i));
            mem_m[1][i] = init_val(16'(i) ^ 16'h00A5);
        end
        ptr_m[0] = 16'h0000;
        ptr_m[1] = 16'h0000;
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (busy0) busy_cnt[0]++;
                    if (busy1) busy_cnt[1]++;
                    if (wr_en0)   sb_check(1, 0, reg_addr0, wr_data0);
                    if (rd_req0)  sb_check(2, 0, reg_addr0, 8'h00);
                    if (wr_done0) sb_check(3, 0, 16'h0000, 8'h00);
                    if (wr_en1)   sb_check(1, 1, reg_addr1, wr_data1);
                    if (rd_req1)  sb_check(2, 1, reg_addr1, 8'h00);
                    if (wr_done1) sb_check(3, 1, 16'h0000, 8'h00);
                end
            end
        join_none

        wait_clk(4);
        @(negedge clk);
        chk("reset_sda", 40'(iic_sda), 40'(1));
        chk("reset_outputs0", 40'({reg_addr0, wr_data0, wr_en0, rd_req0, busy0, wr_done0}), 40'(0));
        chk("reset_outputs1", 40'({reg_addr1, wr_data1, wr_en1, rd_req1, busy1, wr_done1}), 40'(0));
        rst_n = 1'b1;
        wait_clk(5);

        rd_txn(0, 1'b1, 16'h0012, 2);
        wq = '{8'hA5, 8'h3C};
        wr_txn(0, 16'h0012, 1'b0);
        wrong_txn();
        wq = '{8'h11, 8'h22};
        wr_txn(1, 16'h00FF, 1'b0);
        wq.delete();
        wr_txn(0, 16'h0100, 1'b1);
        wq = '{8'h77};
        wr_txn(0, 16'hFFFF, 1'b0);
        rd_txn(0, 1'b1, 16'h0012, 2);
        reset_mid_ack();

        for (int t = 0; t < 20; t++) begin
            inst = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 4));
            n    = int'($urandom_range(1, 3));
            a    = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            case (kind)
                0: begin
                    wq.delete();
                    repeat (n) wq.push_back(8'($urandom));
                    wr_txn(inst, a, 1'b0);
                end
                1: rd_txn(inst, 1'b1, a, n);
                2: rd_txn(inst, 1'b0, a, n);
                3: wrong_txn();
                default: begin
                    wq.delete();
                    if ($urandom_range(0, 1) == 1) wq.push_back(8'($urandom));
                    wr_txn(inst, a, 1'b1);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
